// File: rtl/max7219_rx.sv
// MAX7219-compatible serial receiver: oversampled SPI frame capture plus register file.
// Optional daisy-chain output enabled by defining MAX7219_RX_DOUT_EN.
module max7219_rx (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_clk,
  input  logic       din,
  input  logic       cs,
  input  logic [2:0] rd_digit,
  output logic [7:0] rd_data,
  output logic [7:0] decode_mode,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       shutdown_n,
  output logic       display_test,
  output logic       wr_valid,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic       dout
);

  // Bits [15:12] only matter when they are forwarded on dout.
`ifdef MAX7219_RX_DOUT_EN
  localparam int unsigned SW = 16;
`else
  localparam int unsigned SW = 12;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t        state;
  logic          sclk_s1, sclk_s2, sclk_s3;
  logic          din_s1, din_s2, din_s3;
  logic          cs_s1, cs_s2, cs_s3;
  logic [1:0]    sync_ok;
  logic          armed;
  logic          sclk_rise, cs_rise, cs_fall;
  logic [4:0]    bit_cnt, cnt_nxt;
  logic [SW-1:0] shreg, shreg_nxt;
  logic [7:0]    digit [8];

  // armed is only set once cs has been genuinely seen high after reset, so a
  // cs that was already low across reset cannot open a frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      din_s1  <= 1'b0;
      din_s2  <= 1'b0;
      din_s3  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
      sync_ok <= '0;
      armed   <= 1'b0;
    end else begin
      sclk_s1 <= spi_clk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      din_s1  <= din;
      din_s2  <= din_s1;
      din_s3  <= din_s2;
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      sync_ok <= {sync_ok[0], 1'b1};
      if (sync_ok[1] && cs_s2) begin
        armed <= 1'b1;
      end
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign cs_rise   = cs_s2 & ~cs_s3;
  assign cs_fall   = ~cs_s2 & cs_s3;

  // Shift happens before the frame-length judgement when both edges coincide.
  always_comb begin
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    if (sclk_rise) begin
      shreg_nxt = {shreg[SW-2:0], din_s3};
      if (bit_cnt != 5'd31) begin
        cnt_nxt = bit_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall && armed) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        SHIFT: begin
          shreg   <= shreg_nxt;
          bit_cnt <= cnt_nxt;
          if (cs_rise) begin
            if (cnt_nxt[4]) begin
              state <= COMMIT;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        COMMIT: begin
          wr_valid <= 1'b1;
          wr_addr  <= shreg[11:8];
          wr_data  <= shreg[7:0];
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register file follows the wr_valid pulse, so outputs change one cycle later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 8; i++) begin
        digit[i] <= '0;
      end
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown_n   <= 1'b0;
      display_test <= 1'b0;
      rd_data      <= '0;
    end else begin
      rd_data <= digit[rd_digit];
      if (wr_valid) begin
        case (wr_addr)
          4'h1, 4'h2, 4'h3, 4'h4,
          4'h5, 4'h6, 4'h7, 4'h8: digit[3'(wr_addr - 4'd1)] <= wr_data;
          4'h9: decode_mode  <= wr_data;
          4'hA: intensity    <= wr_data[3:0];
          4'hB: scan_limit   <= wr_data[2:0];
          4'hC: shutdown_n   <= wr_data[0];
          4'hF: display_test <= wr_data[0];
          default: ;
        endcase
      end
    end
  end

`ifdef MAX7219_RX_DOUT_EN
  logic sclk_fall;
  assign sclk_fall = ~sclk_s2 & sclk_s3;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout <= 1'b0;
    end else if (cs_fall) begin
      dout <= 1'b0;
    end else if (sclk_fall) begin
      dout <= shreg[15];
    end
  end
`else
  assign dout = 1'b0;
`endif

endmodule
